dcache: RTL and testbench

DCACHE -- requirements
Module: dcache

---
 rtl/custom_types_pkg.sv | 46 ++++
 rtl/dcache_if.sv | 27 ++
 rtl/dcache_frame_array.sv | 33 +++
 rtl/dcache.sv | 139 +++++++++++++
 tb/tb_dcache.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/custom_types_pkg.sv
// rtl/custom_types_pkg.sv - shared frame, state and address types for dcache
package custom_types_pkg;

    localparam int TAG_W = 30;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } dcache_frame_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WB    = 3'd1,
        FETCH = 3'd2
`ifdef DCACHE_FLUSH_EN
        ,
        FLUSH = 3'd3,
        DONE  = 3'd4
`endif
    } dcache_state_t;

    // Widest possible split (SETS=64 index, SETS=2 tag); unused upper bits stay zero.
    typedef struct packed {
        logic [29:0] tag;
        logic [5:0]  index;
        logic [1:0]  offset;
    } dcache_addr_t;

    function automatic dcache_addr_t split_addr(input logic [31:0] a, input int iw);
        dcache_addr_t r;
        r.tag    = a[31:2] >> iw;
        r.index  = a[7:2] & ((6'd1 << iw) - 6'd1);
        r.offset = a[1:0];
        return r;
    endfunction

    function automatic logic [31:0] join_addr(input logic [29:0] tag, input logic [5:0] index,
                                              input int iw);
        logic [29:0] w;
        w = (tag << iw) | {24'd0, index};
        return {w, 2'b00};
    endfunction

endpackage

// File: rtl/dcache_if.sv
// rtl/dcache_if.sv - datapath and memory-side signal bundle for dcache
interface dcache_if;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        halt;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );
endinterface

// File: rtl/dcache_frame_array.sv
// rtl/dcache_frame_array.sv - direct-mapped frame storage with one read and one write port
module dcache_frame_array
    import custom_types_pkg::*;
#(
    parameter int SETS = 16,
    parameter int IW   = $clog2(SETS)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic [IW-1:0] rd_idx,
    output dcache_frame_t rd_frame,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  dcache_frame_t wr_frame
);

    dcache_frame_t frames [SETS];

    // Only valid/dirty are cleared; tag and data are don't-care while invalid.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            for (int i = 0; i < SETS; i++) begin
                frames[i].valid <= 1'b0;
                frames[i].dirty <= 1'b0;
            end
        end else if (wr_en) begin
            frames[wr_idx] <= wr_frame;
        end
    end

    assign rd_frame = frames[rd_idx];

endmodule

// File: rtl/dcache.sv
// rtl/dcache.sv - direct-mapped write-back data cache; DCACHE_FLUSH_EN enables drain-on-halt
module dcache
    import custom_types_pkg::*;
#(
    parameter int SETS = 16
) (
    input logic     CLK,
    input logic     nRST,
    dcache_if.slave bus
);

    localparam int IW = $clog2(SETS);

    dcache_state_t state;
    logic [31:0]   miss_addr;
    dcache_addr_t  req_a, miss_a;
    logic [IW-1:0] req_idx, miss_idx, rd_idx, wr_idx;
    dcache_frame_t frame, wr_frame;
    logic          wr_en, req, hit, frame_dirty;
`ifdef DCACHE_FLUSH_EN
    logic [IW-1:0] flush_idx;
`else
    logic          flushed_q;
`endif
    logic          unused_bits;

    dcache_frame_array #(.SETS(SETS), .IW(IW)) u_frames (
        .CLK      (CLK),
        .nRST     (nRST),
        .rd_idx   (rd_idx),
        .rd_frame (frame),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_frame (wr_frame)
    );

    assign unused_bits = ^{req_a.offset, req_a.index, miss_a.offset, miss_a.index};

    always_comb begin
        req_a    = split_addr(bus.dmemaddr, IW);
        miss_a   = split_addr(miss_addr, IW);
        req_idx  = req_a.index[IW-1:0];
        miss_idx = miss_a.index[IW-1:0];
        // Outside IDLE the frame of interest is the latched miss (or flush cursor), not the live request.
        rd_idx   = (state == IDLE) ? req_idx : miss_idx;
`ifdef DCACHE_FLUSH_EN
        if (state == FLUSH) rd_idx = flush_idx;
`endif
        req         = bus.dmemREN | bus.dmemWEN;
        frame_dirty = frame.valid & frame.dirty;
        hit         = (state == IDLE) && req && frame.valid && (frame.tag == req_a.tag);

        bus.dhit     = hit;
        bus.dmemload = frame.data;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = 32'd0;
        bus.dstore   = 32'd0;
        case (state)
            WB: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = join_addr(frame.tag, 6'(miss_idx), IW);
                bus.dstore = frame.data;
            end
            FETCH: begin
                bus.dREN  = 1'b1;
                bus.daddr = {miss_addr[31:2], 2'b00};
            end
`ifdef DCACHE_FLUSH_EN
            FLUSH: if (frame_dirty) begin
                bus.dWEN   = 1'b1;
                bus.daddr  = join_addr(frame.tag, 6'(flush_idx), IW);
                bus.dstore = frame.data;
            end
`endif
            default: ;
        endcase

`ifdef DCACHE_FLUSH_EN
        bus.flushed = (state == DONE);
`else
        bus.flushed = flushed_q;
`endif

        wr_en    = 1'b0;
        wr_idx   = req_idx;
        wr_frame = frame;
        if (hit && bus.dmemWEN) begin
            wr_en          = 1'b1;
            wr_frame.data  = bus.dmemstore;
            wr_frame.dirty = 1'b1;
        end else if (state == FETCH && !bus.dwait) begin
            wr_en    = 1'b1;
            wr_idx   = miss_idx;
            wr_frame = '{valid: 1'b1, dirty: 1'b0, tag: miss_a.tag, data: bus.dload};
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state     <= IDLE;
            miss_addr <= 32'd0;
`ifdef DCACHE_FLUSH_EN
            flush_idx <= '0;
`else
            flushed_q <= 1'b0;
`endif
        end else begin
`ifndef DCACHE_FLUSH_EN
            flushed_q <= flushed_q | bus.halt;
`endif
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        miss_addr <= bus.dmemaddr;
                        state     <= frame_dirty ? WB : FETCH;
                    end
`ifdef DCACHE_FLUSH_EN
                    else if (bus.halt) begin
                        flush_idx <= '0;
                        state     <= FLUSH;
                    end
`endif
                end
                WB:    if (!bus.dwait) state <= FETCH;
                FETCH: if (!bus.dwait) state <= IDLE;
`ifdef DCACHE_FLUSH_EN
                FLUSH: if (!frame_dirty || !bus.dwait) begin
                    if (flush_idx == IW'(SETS - 1)) state <= DONE;
                    else flush_idx <= flush_idx + 1'b1;
                end
                DONE: state <= DONE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache.sv
// tb/tb_dcache.sv - randomized model-checked bench for dcache (SETS=16), honours DCACHE_FLUSH_EN
module tb_dcache;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    dcache_if bus();
    dcache #(.SETS(16)) dut (.CLK(CLK), .nRST(nRST), .bus(bus.slave));

    localparam int P_IDLE = 0, P_WB = 1, P_FETCH = 2, P_FLUSH = 3, P_DONE = 4;

    int n_cmp = 0, n_fail = 0;
    logic [31:0] mem [logic [31:0]];
    bit dwait_q [$];

    // reference state: what the cache must hold, indexed by word-address modulo 16
    bit          mv [16];
    bit          mdy [16];
    logic [31:0] mtag [16];
    logic [31:0] mdat [16];
    int          mp = P_IDLE;
    int          fi = 0;
    logic [31:0] maddr = 0;
    bit          hseen = 0;
    bit          live = 0;

    int cnt_ren, cnt_wen;
    logic [31:0] first_wa, first_wd, first_ra;
    bit seen_w, seen_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    always @(negedge CLK) begin : model
        bit          req, e_hit, e_ren, e_wen, e_fl, dw;
        logic [31:0] e_addr, e_st, tg;
        int          i, mi;
        req = bus.dmemREN | bus.dmemWEN;
        i   = int'((bus.dmemaddr / 4) % 16);
        tg  = bus.dmemaddr / 64;
        mi  = int'((maddr / 4) % 16);
        e_hit = 0; e_ren = 0; e_wen = 0; e_addr = 0; e_st = 0;
        case (mp)
            P_IDLE:  e_hit = req && mv[i] && (mtag[i] == tg);
            P_WB:    begin e_wen = 1; e_addr = (mtag[mi] * 16 + mi) * 4; e_st = mdat[mi]; end
            P_FETCH: begin e_ren = 1; e_addr = maddr & ~32'd3; end
            P_FLUSH: if (mdy[fi]) begin e_wen = 1; e_addr = (mtag[fi] * 16 + fi) * 4; e_st = mdat[fi]; end
            default: ;
        endcase
`ifdef DCACHE_FLUSH_EN
        e_fl = (mp == P_DONE);
`else
        e_fl = hseen;
`endif
        if (dwait_q.size() > 0) dw = dwait_q.pop_front();
        else dw = ($urandom_range(0, 2) == 0);
        bus.dwait = dw;
        bus.dload = (mp == P_FETCH) ? mem_rd(e_addr) : $urandom;

        if (live) begin
            check("dhit", bus.dhit, e_hit);
            if (e_hit) check("dmemload", bus.dmemload, mdat[i]);
            check("dREN", bus.dREN, e_ren);
            check("dWEN", bus.dWEN, e_wen);
            check("daddr", bus.daddr, e_addr);
            check("dstore", bus.dstore, e_st);
            check("flushed", bus.flushed, e_fl);
        end

        if (nRST) begin
            for (int k = 0; k < 16; k++) begin mv[k] = 0; mdy[k] = 0; end
            mp = P_IDLE; fi = 0; hseen = 0; live = 1;
        end else if (live) begin
            hseen = hseen | bus.halt;
            case (mp)
                P_IDLE: begin
                    if (req && !e_hit) begin
                        maddr = bus.dmemaddr;
                        mp = (mv[i] && mdy[i]) ? P_WB : P_FETCH;
                    end else begin
                        if (e_hit && bus.dmemWEN) begin mdat[i] = bus.dmemstore; mdy[i] = 1; end
`ifdef DCACHE_FLUSH_EN
                        if (bus.halt) begin mp = P_FLUSH; fi = 0; end
`endif
                    end
                end
                P_WB: if (!dw) begin mem[e_addr] = e_st; mp = P_FETCH; end
                P_FETCH: if (!dw) begin
                    mv[mi] = 1; mdy[mi] = 0; mtag[mi] = maddr / 64; mdat[mi] = bus.dload; mp = P_IDLE;
                end
                P_FLUSH: if (!mdy[fi] || !dw) begin
                    if (mdy[fi]) mem[e_addr] = e_st;
                    if (fi == 15) mp = P_DONE; else fi++;
                end
                default: ;
            endcase
        end
    end

    task automatic do_req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input int hold, input int nq, input logic [7:0] pat,
                          output int lat, output logic [31:0] ld);
        @(posedge CLK); #1;
        bus.dmemREN = r; bus.dmemWEN = w; bus.dmemaddr = a; bus.dmemstore = d;
        for (int k = 0; k < nq; k++) dwait_q.push_back(pat[k]);
        lat = -1; ld = 0; cnt_ren = 0; cnt_wen = 0; seen_w = 0; seen_r = 0;
        first_wa = 0; first_wd = 0; first_ra = 0;
        for (int c = 0; c < hold; c++) begin
            @(negedge CLK);
            if (bus.dREN) begin cnt_ren++; if (!seen_r) begin seen_r = 1; first_ra = bus.daddr; end end
            if (bus.dWEN) begin
                cnt_wen++;
                if (!seen_w) begin seen_w = 1; first_wa = bus.daddr; first_wd = bus.dstore; end
            end
            if (bus.dhit) begin lat = c; ld = bus.dmemload; break; end
        end
        @(posedge CLK); #1;
        bus.dmemREN = 0; bus.dmemWEN = 0;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        nRST = 1; bus.halt = 0; bus.dmemREN = 0; bus.dmemWEN = 0;
        dwait_q.delete();
        @(posedge CLK); #1;
        nRST = 0;
    endtask

    initial begin
        int lat, nw, fl_at;
        logic [31:0] ld, wa0, wa1;
        nRST = 1; bus.halt = 0; bus.dmemREN = 0; bus.dmemWEN = 0;
        bus.dmemaddr = 0; bus.dmemstore = 0; bus.dwait = 0; bus.dload = 0;
        repeat (2) @(posedge CLK);
        #1 nRST = 0;
        @(negedge CLK);
        check("rst_dhit", bus.dhit, 0);
        check("rst_dREN", bus.dREN, 0);
        check("rst_dWEN", bus.dWEN, 0);
        check("rst_flushed", bus.flushed, 0);
        check("rst_daddr", bus.daddr, 0);
        check("rst_dstore", bus.dstore, 0);

        mem[32'h40] = 32'hDEADBEEF;
        do_req(1, 0, 32'h40, 0, 60, 4, 8'h07, lat, ld);
        check("cold_ren_cycles", cnt_ren, 3);
        check("cold_ra", first_ra, 32'h40);
        check("cold_lat", lat, 4);
        check("cold_data", ld, 32'hDEADBEEF);

        do_req(0, 1, 32'h40, 32'h12345678, 60, 0, 0, lat, ld);
        check("store_lat", lat, 0);
        check("store_traffic", cnt_ren + cnt_wen, 0);
        do_req(1, 0, 32'h40, 0, 60, 0, 0, lat, ld);
        check("reload_lat", lat, 0);
        check("reload_data", ld, 32'h12345678);

        do_req(1, 0, 32'h440, 0, 60, 4, 8'h00, lat, ld);
        check("conf_wb_addr", first_wa, 32'h40);
        check("conf_wb_data", first_wd, 32'h12345678);
        check("conf_fetch_addr", first_ra, 32'h440);
        check("conf_lat", lat, 3);

        // reset lands while FETCH is stalled
        @(posedge CLK); #1;
        bus.dmemREN = 1; bus.dmemaddr = 32'h80;
        repeat (5) dwait_q.push_back(1'b1);
        @(posedge CLK); #1;
        nRST = 1; bus.dmemREN = 0;
        @(negedge CLK);
        check("rstf_dREN_before", bus.dREN, 1);
        @(posedge CLK); #1;
        nRST = 0;
        @(negedge CLK);
        check("rstf_dREN_after", bus.dREN, 0);
        dwait_q.delete();
        do_req(1, 0, 32'h40, 0, 60, 0, 0, lat, ld);
        check("rstf_miss", lat >= 2, 1);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, tsel;
            bit r, w;
            int hold, gap;
            case ($urandom_range(0, 3))
                0: tsel = 0; 1: tsel = 1; 2: tsel = 2; default: tsel = 32'h3FFFFFF;
            endcase
            a = (tsel << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0: begin r = 1; w = 0; end
                1: begin r = 0; w = 1; end
                default: begin r = 1; w = 1; end
            endcase
            hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 60;
            do_req(r, w, a, $urandom, hold, 0, 0, lat, ld);
            if (hold == 60) check("rand_timeout", lat >= 0, 1);
            gap = $urandom_range(0, 2);
            repeat (gap) @(posedge CLK);
            #1;
        end

        do_reset();
        do_req(0, 1, 32'h04, 32'hAAAA0001, 60, 0, 0, lat, ld);
        do_req(0, 1, 32'h14, 32'hAAAA0005, 60, 0, 0, lat, ld);
        @(posedge CLK); #1;
        bus.halt = 1;
        repeat (30) dwait_q.push_back(1'b0);
        nw = 0; fl_at = -1; wa0 = 0; wa1 = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge CLK);
            if (bus.dWEN) begin
                if (nw == 0) wa0 = bus.daddr;
                if (nw == 1) wa1 = bus.daddr;
                nw++;
            end
            if (bus.flushed && fl_at < 0) fl_at = c;
        end
`ifdef DCACHE_FLUSH_EN
        check("flush_writes", nw, 2);
        check("flush_wa0", wa0, 32'h04);
        check("flush_wa1", wa1, 32'h14);
        check("flush_time", fl_at, 17);
`else
        check("halt_writes", nw, 0);
        check("halt_time", fl_at, 1);
`endif
        @(posedge CLK); #1;
        bus.dmemREN = 1; bus.dmemaddr = 32'h04;
        @(negedge CLK);
`ifdef DCACHE_FLUSH_EN
        check("done_dhit", bus.dhit, 0);
`else
        check("halted_dhit", bus.dhit, 1);
`endif
        check("flushed_held", bus.flushed, 1);
        do_reset();
        @(negedge CLK);
        check("final_flushed", bus.flushed, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
